// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
//   Shared definitions for the execute/write-back stage:
//     - operation codes presented on issue_op
//     - FSM state encoding (IDLE / ITER / WB)
//     - is_iter_op(): true for the multi-cycle multiply/divide operations
// -----------------------------------------------------------------------------
package exec_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_SLTU  = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;
    localparam logic [3:0] OP_MULHU = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;
    localparam logic [3:0] OP_REMU  = 4'd12;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ITER = 2'd1;
    localparam state_t ST_WB   = 2'd2;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) ||
               (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/exec_muldiv_iter.sv
// -----------------------------------------------------------------------------
// exec_muldiv_iter
//   Bit-serial unsigned multiplier / restoring divider. One step per cycle,
//   DATA_WIDTH steps per operation.
//
//   Ports:
//     clk, reset  rising-edge clock, synchronous active-high reset
//     start       load operands and begin iterating (ignored while active)
//     op          operation code, latched at start (MUL/MULHU/DIVU/REMU)
//     a, b        multiplicand/multiplier or dividend/divisor, latched at start
//     done        high during the final step
//     result      value the final step produces; valid while done is high
//
//   Both algorithms share the same registers: hi holds the product's upper
//   half or the partial remainder, lo holds the multiplier or the dividend
//   that turns into the quotient, opnd holds the multiplicand or divisor.
// -----------------------------------------------------------------------------
module exec_muldiv_iter
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                  active;
    logic [CW-1:0]         count;
    logic [3:0]            op_q;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic [DATA_WIDTH-1:0] opnd;

    logic                  is_div;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   shifted;
    logic                  ge;
    logic [DATA_WIDTH-1:0] hi_next;
    logic [DATA_WIDTH-1:0] lo_next;

    assign is_div = (op_q == OP_DIVU) || (op_q == OP_REMU);

    // One iteration step, computed combinationally so the final result is
    // available to the parent on the same edge that retires the last step.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        sum     = '0;
        shifted = '0;
        ge      = 1'b0;
        hi_next = hi;
        lo_next = lo;
        if (is_div) begin
            // Restoring division: shift the next dividend bit into the
            // remainder, subtract the divisor only if it fits. A zero
            // divisor always fits, yielding all-ones quotient and the
            // dividend as remainder.
            shifted = {hi, lo[DATA_WIDTH-1]};
            ge      = (shifted >= {1'b0, opnd});
            hi_next = ge ? DATA_WIDTH'(shifted - {1'b0, opnd})
                         : shifted[DATA_WIDTH-1:0];
            lo_next = {lo[DATA_WIDTH-2:0], ge};
        end else begin
            // Shift-add multiply: the carry out of the add re-enters the
            // top of hi, the low bit of the sum shifts into lo.
            sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
            hi_next = sum[DATA_WIDTH:1];
            lo_next = {sum[0], lo[DATA_WIDTH-1:1]};
        end
    end

    always_comb begin
        unique case (op_q)
            OP_MULHU, OP_REMU: result = hi_next;
            default:           result = lo_next;
        endcase
    end

    assign done = active && (count == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            count  <= '0;
            op_q   <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
        end else if (start && !active) begin
            active <= 1'b1;
            count  <= CW'(DATA_WIDTH - 1);
            op_q   <= op;
            hi     <= '0;
            lo     <= a;
            opnd   <= b;
        end else if (active) begin
            hi <= hi_next;
            lo <= lo_next;
            if (count == '0) begin
                active <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/exec_unit.sv
// -----------------------------------------------------------------------------
// exec_unit
//   Execute / write-back stage between the register-file read ports and its
//   write port. Simple ALU ops retire one cycle after accept; MUL/MULHU/DIVU/
//   REMU iterate one bit per cycle in exec_muldiv_iter.
//
//   Ports:
//     clk, reset             rising-edge clock, synchronous active-high reset
//     issue_valid/ready      instruction handshake (accept = valid && ready)
//     issue_op               operation code (exec_pkg OP_*)
//     issue_a, issue_b       source operands from the register file
//     issue_rd               destination register index
//     wb_enable              one-cycle write strobe (never for rd == 0)
//     wb_addr, wb_data       write address/data, hold between strobes
//     busy                   multi-cycle operation in progress
// -----------------------------------------------------------------------------
module exec_unit
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [3:0]            issue_op,
    input  logic [DATA_WIDTH-1:0] issue_a,
    input  logic [DATA_WIDTH-1:0] issue_b,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  wb_enable,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  busy
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  accept;
    logic                  start_iter;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  mdu_done;
    logic [DATA_WIDTH-1:0] mdu_result;

    assign issue_ready = (state != ST_ITER);
    assign busy        = (state == ST_ITER);
    assign accept      = issue_valid && issue_ready;
    assign start_iter  = accept && is_iter_op(issue_op);

    // Single-cycle ALU; iterative and undefined op codes produce 0 here.
    always_comb begin
        alu_result = '0;
        case (issue_op)
            OP_ADD:  alu_result = issue_a + issue_b;
            OP_SUB:  alu_result = issue_a - issue_b;
            OP_AND:  alu_result = issue_a & issue_b;
            OP_OR:   alu_result = issue_a | issue_b;
            OP_XOR:  alu_result = issue_a ^ issue_b;
            OP_SLL:  alu_result = issue_a << issue_b[2:0];
            OP_SRL:  alu_result = issue_a >> issue_b[2:0];
            OP_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}},
                                   ($signed(issue_a) < $signed(issue_b))};
            OP_SLTU: alu_result = {{(DATA_WIDTH-1){1'b0}}, (issue_a < issue_b)};
            default: alu_result = '0;
        endcase
    end

    exec_muldiv_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (start_iter),
        .op     (issue_op),
        .a      (issue_a),
        .b      (issue_b),
        .done   (mdu_done),
        .result (mdu_result)
    );

    // wb_addr/wb_data only move when a strobe is issued, so they keep the
    // last written value in every other cycle (including rd == 0 results).
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rd_q      <= '0;
            wb_enable <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
        end else begin
            wb_enable <= 1'b0;
            case (state)
                ST_IDLE, ST_WB: begin
                    if (accept) begin
                        if (is_iter_op(issue_op)) begin
                            state <= ST_ITER;
                            rd_q  <= issue_rd;
                        end else begin
                            state <= ST_WB;
                            if (issue_rd != '0) begin
                                wb_enable <= 1'b1;
                                wb_addr   <= issue_rd;
                                wb_data   <= alu_result;
                            end
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ITER: begin
                    if (mdu_done) begin
                        state <= ST_WB;
                        if (rd_q != '0) begin
                            wb_enable <= 1'b1;
                            wb_addr   <= rd_q;
                            wb_data   <= mdu_result;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_exec_unit
//   Self-checking bench for exec_unit. Expected results come from a plain
//   arithmetic reference model; timing expectations (1-cycle simple ops,
//   DATA_WIDTH+1-cycle iterative ops) are checked cycle by cycle.
// -----------------------------------------------------------------------------
module tb_exec_unit;

    localparam int DW = 8;
    localparam int AW = 5;

    localparam logic [3:0] T_ADD = 4'd0, T_SUB = 4'd1, T_AND = 4'd2, T_OR = 4'd3,
                           T_XOR = 4'd4, T_SLL = 4'd5, T_SRL = 4'd6, T_SLT = 4'd7,
                           T_SLTU = 4'd8, T_MUL = 4'd9, T_MULHU = 4'd10,
                           T_DIVU = 4'd11, T_REMU = 4'd12;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid;
    logic          issue_ready;
    logic [3:0]    issue_op;
    logic [DW-1:0] issue_a;
    logic [DW-1:0] issue_b;
    logic [AW-1:0] issue_rd;
    logic          wb_enable;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    exec_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_a     (issue_a),
        .issue_b     (issue_b),
        .issue_rd    (issue_rd),
        .wb_enable   (wb_enable),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the arithmetic definitions.
    function automatic logic [DW-1:0] ref_model(input logic [3:0] op,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        int ua, ub, sa, sb, r;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            T_ADD:   r = ua + ub;
            T_SUB:   r = ua - ub;
            T_AND:   r = ua & ub;
            T_OR:    r = ua | ub;
            T_XOR:   r = ua ^ ub;
            T_SLL:   r = ua << (ub % 8);
            T_SRL:   r = ua >> (ub % 8);
            T_SLT:   r = (sa < sb) ? 1 : 0;
            T_SLTU:  r = (ua < ub) ? 1 : 0;
            T_MUL:   r = ua * ub;
            T_MULHU: r = (ua * ub) / 256;
            T_DIVU:  r = (ub == 0) ? 255 : ua / ub;
            T_REMU:  r = (ub == 0) ? ua : ua % ub;
            default: r = 0;
        endcase
        return r[DW-1:0];
    endfunction

    function automatic bit is_multi(input logic [3:0] op);
        return (op >= T_MUL) && (op <= T_REMU);
    endfunction

    // Called at posedge+1 with the unit ready; issues one instruction,
    // scrambles the inputs after accept, and checks the whole latency window.
    // Returns at posedge+1 of the write-back cycle.
    task automatic do_op(input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [AW-1:0] rd);
        logic [DW-1:0] exp;
        int            lat;
        exp = ref_model(op, a, b);
        lat = is_multi(op) ? DW : 0;
        check("ready_at_issue", issue_ready, 1);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_a     = a;
        issue_b     = b;
        issue_rd    = rd;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        issue_op    = 4'($urandom);
        issue_a     = DW'($urandom);
        issue_b     = DW'($urandom);
        issue_rd    = AW'($urandom);
        for (int i = 0; i < lat; i++) begin
            check("iter_busy", busy, 1);
            check("iter_ready", issue_ready, 0);
            check("iter_wb_quiet", wb_enable, 0);
            @(posedge clk); #1;
        end
        check($sformatf("wb_enable op%0d rd%0d", op, rd), wb_enable, (rd != 0));
        if (rd != 0) begin
            check("wb_addr", wb_addr, rd);
            check($sformatf("wb_data op%0d a%0h b%0h", op, a, b), wb_data, exp);
        end
        check("wb_ready", issue_ready, 1);
        check("wb_not_busy", busy, 0);
    endtask

    initial begin
        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_op    = '0;
        issue_a     = '0;
        issue_b     = '0;
        issue_rd    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_enable", wb_enable, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", issue_ready, 1);

        // Directed cases; consecutive calls issue in the WB cycle, so the
        // simple ops here run back to back at one per cycle.
        do_op(T_ADD,  8'hF0, 8'h20, 5'd3);
        do_op(T_SUB,  8'h05, 8'h07, 5'd1);
        do_op(T_SLT,  8'h80, 8'h01, 5'd2);
        do_op(T_SLTU, 8'h80, 8'h01, 5'd4);
        do_op(T_MUL,  8'h13, 8'h11, 5'd5);
        do_op(T_MULHU, 8'h13, 8'h11, 5'd6);
        do_op(T_DIVU, 8'd200, 8'd7, 5'd7);
        do_op(T_REMU, 8'd200, 8'd7, 5'd8);
        do_op(T_DIVU, 8'd9, 8'd0, 5'd9);
        do_op(T_REMU, 8'd9, 8'd0, 5'd10);
        do_op(T_SLL,  8'h81, 8'h0B, 5'd12);
        do_op(T_SRL,  8'h81, 8'hFF, 5'd13);
        do_op(4'd14,  8'h55, 8'h66, 5'd14);
        do_op(T_ADD,  8'h01, 8'h01, 5'd0);
        do_op(T_ADD,  8'h02, 8'h03, 5'd11);

        // Single-pulse check: no accept in WB returns to IDLE quietly.
        @(posedge clk); #1;
        check("pulse_single", wb_enable, 0);
        check("idle_ready", issue_ready, 1);
        check("hold_wb_addr", wb_addr, 11);
        check("hold_wb_data", wb_data, 5);

        // Randomized mix over the whole op space.
        for (int i = 0; i < 60; i++) begin
            do_op(4'($urandom_range(0, 15)), DW'($urandom), DW'($urandom),
                  AW'($urandom_range(0, 31)));
        end

        // Reset in the 4th ITER cycle of a DIVU discards it.
        @(posedge clk); #1;
        issue_valid = 1'b1;
        issue_op    = T_DIVU;
        issue_a     = 8'd100;
        issue_b     = 8'd3;
        issue_rd    = 5'd20;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_wb_enable", wb_enable, 0);
        check("mid_rst_wb_addr", wb_addr, 0);
        check("mid_rst_wb_data", wb_data, 0);
        check("mid_rst_busy", busy, 0);
        @(posedge clk); #1;
        check("mid_rst_ready", issue_ready, 1);
        for (int i = 0; i < DW + 2; i++) begin
            check("discarded_no_wb", wb_enable, 0);
            @(posedge clk); #1;
        end
        do_op(T_ADD, 8'h21, 8'h12, 5'd15);
        @(posedge clk); #1;
        check("final_quiet", wb_enable, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
